// File: rtl/fft_mag_streamer.sv
// Streams exact squared magnitude re^2+im^2 for FFT bins BIN_LO..BIN_HI, read over the core's DMA port.
// Defining FFT_MAG_PEAK_EN builds a per-frame peak tracker; otherwise peak_bin_o/peak_mag_o are tied to 0.
module fft_mag_streamer #(
    parameter int FFT_N      = 10,
    parameter int DW         = 16,
    parameter int BIN_LO     = 0,
    parameter int BIN_HI     = 511,
    parameter int RD_LAT     = 2,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 fft_done_i,
    input  logic signed [7:0]    bfpexp_i,
    output logic                 dmaact_o,
    output logic [FFT_N-1:0]     dmaa_o,
    input  logic signed [DW-1:0] dmadr_real_i,
    input  logic signed [DW-1:0] dmadr_imag_i,
    output logic                 mag_valid_o,
    input  logic                 mag_ready_i,
    output logic [2*DW-1:0]      mag_data_o,
    output logic [FFT_N-1:0]     mag_bin_o,
    output logic                 mag_last_o,
    output logic signed [8:0]    mag_exp_o,
    output logic                 busy_o,
    output logic                 frame_done_o,
    output logic [FFT_N-1:0]     peak_bin_o,
    output logic [2*DW-1:0]      peak_mag_o
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam int PW = 2 * DW;
    localparam int EW = 1 + FFT_N + PW;
    localparam logic [FFT_N-1:0] ADDR_LO = FFT_N'(BIN_LO);
    localparam logic [FFT_N-1:0] ADDR_HI = FFT_N'(BIN_HI);

    typedef enum logic [2:0] {IDLE, ISSUE, DRAIN, DONE, REARM} state_t;

    function automatic logic [PW-1:0] square(input logic signed [DW-1:0] x);
        logic signed [PW-1:0] w;
        w = PW'(x);
        return $unsigned(w * w);
    endfunction

    // Two squares are each at most 2^(2DW-2), so the sum always fits in PW bits.
    function automatic logic [PW-1:0] mag_sum(input logic [PW-1:0] a, input logic [PW-1:0] b);
        return a + b;
    endfunction

    state_t              r_state;
    logic [FFT_N-1:0]    r_addr;
    logic                r_busy;
    logic                r_done;
    logic signed [8:0]   r_exp;

    logic [RD_LAT-1:0]   r_rd_vld;
    logic [FFT_N-1:0]    r_rd_bin [RD_LAT];

    logic [PW-1:0]       r_sq_re_p0;
    logic [PW-1:0]       r_sq_im_p0;
    logic [FFT_N-1:0]    r_bin_p0;
    logic                r_vld_p0;

    logic [PW-1:0]       r_sum_p1;
    logic [FFT_N-1:0]    r_bin_p1;
    logic                r_last_p1;
    logic                r_vld_p1;

    logic [EW-1:0]       r_mem [FIFO_DEPTH];
    logic [AW-1:0]       r_wr_ptr;
    logic [AW-1:0]       r_rd_ptr;
    logic [CW-1:0]       r_count;
    logic [CW-1:0]       r_inflight;

    logic [CW:0]         w_occupancy;
    logic                w_credit;
    logic                w_issue;
    logic                w_push;
    logic                w_pop;
    logic                w_valid;
    logic                w_start;
    logic                w_drain_done;
    logic [EW-1:0]       w_head;

    // Reads still in the pipeline count against FIFO space so a stalled sink can never overflow it.
    assign w_occupancy  = {1'b0, r_count} + {1'b0, r_inflight};
    assign w_credit     = w_occupancy < (CW+1)'(FIFO_DEPTH);
    assign w_issue      = (r_state == ISSUE) && w_credit;
    assign w_push       = r_vld_p1;
    assign w_valid      = (r_count != '0);
    assign w_pop        = w_valid && mag_ready_i;
    assign w_start      = (r_state == IDLE) && fft_done_i;
    assign w_drain_done = (r_state == DRAIN) && (r_inflight == '0) && (r_count == '0);
    assign w_head       = r_mem[r_rd_ptr];

    assign dmaact_o     = w_issue;
    assign dmaa_o       = r_addr;
    assign mag_valid_o  = w_valid;
    assign mag_data_o   = w_valid ? w_head[PW-1:0] : '0;
    assign mag_bin_o    = w_valid ? w_head[PW +: FFT_N] : '0;
    assign mag_last_o   = w_valid & w_head[EW-1];
    assign mag_exp_o    = r_exp;
    assign busy_o       = r_busy;
    assign frame_done_o = r_done;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
            r_addr  <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_exp   <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_start) begin
                        r_exp   <= {bfpexp_i, 1'b0};
                        r_addr  <= ADDR_LO;
                        r_busy  <= 1'b1;
                        r_state <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (w_issue) begin
                        r_addr <= r_addr + FFT_N'(1);
                        if (r_addr == ADDR_HI) r_state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (w_drain_done) begin
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= DONE;
                    end
                end
                DONE: begin
                    r_state <= REARM;
                end
                REARM: begin
                    if (!fft_done_i) r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_rd_vld <= '0;
            r_vld_p0 <= 1'b0;
            r_vld_p1 <= 1'b0;
        end else begin
            r_rd_vld[0] <= w_issue;
            for (int i = 1; i < RD_LAT; i++) r_rd_vld[i] <= r_rd_vld[i-1];
            r_vld_p0 <= r_rd_vld[RD_LAT-1];
            r_vld_p1 <= r_vld_p0;
        end
    end

    always_ff @(posedge clk) begin
        r_rd_bin[0] <= r_addr;
        for (int i = 1; i < RD_LAT; i++) r_rd_bin[i] <= r_rd_bin[i-1];
        // p0: DMA read data has landed; register both squares
        r_sq_re_p0 <= square(dmadr_real_i);
        r_sq_im_p0 <= square(dmadr_imag_i);
        r_bin_p0   <= r_rd_bin[RD_LAT-1];
        // p1: magnitude sum, pushed into the FIFO on the following edge
        r_sum_p1   <= mag_sum(r_sq_re_p0, r_sq_im_p0);
        r_bin_p1   <= r_bin_p0;
        r_last_p1  <= (r_bin_p0 == ADDR_HI);
        if (w_push) r_mem[r_wr_ptr] <= {r_last_p1, r_bin_p1, r_sum_p1};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_inflight <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: ;
            endcase
            case ({w_issue, w_push})
                2'b10:   r_inflight <= r_inflight + CW'(1);
                2'b01:   r_inflight <= r_inflight - CW'(1);
                default: ;
            endcase
        end
    end

`ifdef FFT_MAG_PEAK_EN
    logic [FFT_N-1:0] r_pk_bin;
    logic [PW-1:0]    r_pk_mag;
    logic [FFT_N-1:0] r_peak_bin;
    logic [PW-1:0]    r_peak_mag;

    // Strictly-greater update keeps the lowest bin on ties.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_pk_bin   <= '0;
            r_pk_mag   <= '0;
            r_peak_bin <= '0;
            r_peak_mag <= '0;
        end else begin
            if (w_start) begin
                r_pk_bin <= ADDR_LO;
                r_pk_mag <= '0;
            end else if (w_push && (r_sum_p1 > r_pk_mag)) begin
                r_pk_bin <= r_bin_p1;
                r_pk_mag <= r_sum_p1;
            end
            if (w_drain_done) begin
                r_peak_bin <= r_pk_bin;
                r_peak_mag <= r_pk_mag;
            end
        end
    end

    assign peak_bin_o = r_peak_bin;
    assign peak_mag_o = r_peak_mag;
`else
    assign peak_bin_o = '0;
    assign peak_mag_o = '0;
`endif

endmodule

// File: tb/tb_fft_mag_streamer.sv
// Scoreboard bench for fft_mag_streamer: full frames, extreme values, backpressure, reset abort, bin window, peak/exponent.
`timescale 1ns/1ps
module tb_fft_mag_streamer;

    typedef struct packed {
        logic [9:0]  bin;
        logic        last;
        logic [31:0] data;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic fft_done = 1'b0;
    logic w_fft_done = 1'b0;
    logic ready = 1'b1;
    logic signed [7:0] bfpexp = 8'sd0;

    logic dmaact, mvalid, mlast, busy, fdone;
    logic [9:0] dmaa, mbin, pbin;
    logic [31:0] mdata, pmag;
    logic signed [15:0] dr_re, dr_im;
    logic signed [8:0] mexp;

    logic w_dmaact, w_valid, w_last, w_busy, w_fdone;
    logic [9:0] w_dmaa, w_bin, w_pbin;
    logic [31:0] w_data, w_pmag;
    logic signed [15:0] w_re, w_im;
    logic signed [8:0] w_exp;

    logic signed [15:0] re_mem [1024];
    logic signed [15:0] im_mem [1024];
    logic [9:0] a1 = '0, a2 = '0, b1 = '0, b2 = '0;

    int n_chk = 0, n_pass = 0, cyc = 0;
    exp_t sb[$];
    exp_t sbw[$];
    exp_t held, e, ew;
    bit held_v = 0;
    int fd_cnt = 0, issued = 0, popped = 0, max_out = 0;
    int w_fd = 0, w_iss = 0, w_pop = 0;
    bit halt_seen = 0, last_iss = 0;
    bit tog_en = 0;
    int tog_cnt = 0;
    logic [9:0]  exp_pk_bin;
    logic [31:0] exp_pk_mag;

    fft_mag_streamer u_dut (
        .clk(clk), .reset(reset), .fft_done_i(fft_done), .bfpexp_i(bfpexp),
        .dmaact_o(dmaact), .dmaa_o(dmaa), .dmadr_real_i(dr_re), .dmadr_imag_i(dr_im),
        .mag_valid_o(mvalid), .mag_ready_i(ready), .mag_data_o(mdata), .mag_bin_o(mbin),
        .mag_last_o(mlast), .mag_exp_o(mexp), .busy_o(busy), .frame_done_o(fdone),
        .peak_bin_o(pbin), .peak_mag_o(pmag)
    );

    fft_mag_streamer #(.BIN_LO(100), .BIN_HI(103)) u_win (
        .clk(clk), .reset(reset), .fft_done_i(w_fft_done), .bfpexp_i(bfpexp),
        .dmaact_o(w_dmaact), .dmaa_o(w_dmaa), .dmadr_real_i(w_re), .dmadr_imag_i(w_im),
        .mag_valid_o(w_valid), .mag_ready_i(1'b1), .mag_data_o(w_data), .mag_bin_o(w_bin),
        .mag_last_o(w_last), .mag_exp_o(w_exp), .busy_o(w_busy), .frame_done_o(w_fdone),
        .peak_bin_o(w_pbin), .peak_mag_o(w_pmag)
    );

    always #5 clk = ~clk;

    // DMA read port model with a two-cycle read latency
    always @(posedge clk) begin
        a1 <= dmaa;
        a2 <= a1;
        b1 <= w_dmaa;
        b2 <= b1;
    end
    assign dr_re = re_mem[a2];
    assign dr_im = im_mem[a2];
    assign w_re  = re_mem[b2];
    assign w_im  = im_mem[b2];

    task automatic check(input string name, input longint act, input longint req);
        n_chk++;
        if (act == req) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, req);
    endtask

    function automatic logic [31:0] mag_of(input int k);
        longint r, i;
        r = longint'(re_mem[k]);
        i = longint'(im_mem[k]);
        return 32'(r * r + i * i);
    endfunction

    task automatic push_frame(input int lo, input int hi, input bit win);
        exp_t x;
        exp_pk_bin = 10'(lo);
        exp_pk_mag = '0;
        for (int k = lo; k <= hi; k++) begin
            x.bin  = 10'(k);
            x.last = (k == hi);
            x.data = mag_of(k);
            if (win) sbw.push_back(x);
            else sb.push_back(x);
            if (x.data > exp_pk_mag) begin
                exp_pk_bin = 10'(k);
                exp_pk_mag = x.data;
            end
        end
    endtask

    task automatic wait_frame(input string name);
        int fd0;
        bit got;
        fd0 = fd_cnt;
        got = 0;
        for (int n = 0; n < 4000; n++) begin
            @(posedge clk);
            if (fd_cnt != fd0) begin
                got = 1;
                break;
            end
        end
        check({name, "_done"}, longint'(got), 1);
        repeat (10) @(posedge clk);
        #1;
        check({name, "_one_pulse"}, fd_cnt, fd0 + 1);
        check({name, "_sb_empty"}, sb.size(), 0);
        check({name, "_busy_low"}, busy, 0);
    endtask

    task automatic first_issue(input string name, output int t0);
        t0 = -1;
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            if (dmaact) begin
                t0 = cyc;
                break;
            end
        end
        check({name, "_issue_seen"}, longint'(t0 >= 0), 1);
        check({name, "_first_addr"}, dmaa, 0);
    endtask

    task automatic check_all_zero(input string name);
        check({name, "_valid"}, mvalid, 0);
        check({name, "_dmaact"}, dmaact, 0);
        check({name, "_dmaa"}, dmaa, 0);
        check({name, "_word"}, {mbin, mlast, mdata}, 0);
        check({name, "_exp"}, mexp, 0);
        check({name, "_busy_done"}, {busy, fdone}, 0);
        check({name, "_peak"}, {pbin, pmag}, 0);
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    initial forever begin
        @(posedge clk);
        #1;
        if (tog_en) begin
            tog_cnt++;
            if (tog_cnt == 3) begin
                tog_cnt = 0;
                ready = ~ready;
            end
        end
    end

    // Monitor for the full-range instance: ordering, content, hold-while-stalled, credit usage
    initial forever begin
        @(negedge clk);
        if (reset) begin
            held_v = 0;
        end else begin
            if (fdone) fd_cnt++;
            if (dmaact) begin
                issued++;
                if (dmaa == 10'd511) last_iss = 1;
            end
            if (busy && !dmaact && !last_iss) halt_seen = 1;
            if (issued - popped > max_out) max_out = issued - popped;
            if (held_v) check("hold_stable", {mvalid, mbin, mlast, mdata}, {1'b1, held});
            if (mvalid && ready) begin
                popped++;
                if (sb.size() == 0) begin
                    n_chk++;
                    $display("FAIL extra_word: bin %0d data %0h, expected none", mbin, mdata);
                end else begin
                    e = sb.pop_front();
                    check("word", {mbin, mlast, mdata}, e);
                end
            end
            held_v = mvalid && !ready;
            held   = {mbin, mlast, mdata};
        end
    end

    // Monitor for the windowed instance
    initial forever begin
        @(negedge clk);
        if (!reset) begin
            if (w_fdone) w_fd++;
            if (w_dmaact) w_iss++;
            if (w_valid) begin
                w_pop++;
                if (sbw.size() == 0) begin
                    n_chk++;
                    $display("FAIL win_extra_word: bin %0d data %0h, expected none", w_bin, w_data);
                end else begin
                    ew = sbw.pop_front();
                    check("win_word", {w_bin, w_last, w_data}, ew);
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: time limit reached, expected bench completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int t0, t1, n, wi0, wp0, wf0, fd0;
        bit found;

        for (int k = 0; k < 1024; k++) begin
            re_mem[k] = 16'(k);
            im_mem[k] = 16'sd0;
        end
        repeat (3) @(posedge clk);
        #1;
        check_all_zero("rst");
        reset = 1'b0;

        // Frame 1: re=k, im=0, bin 7 carries the most negative value on both parts
        re_mem[7] = -16'sd32768;
        im_mem[7] = -16'sd32768;
        @(posedge clk);
        #1;
        bfpexp = 8'sd5;
        fft_done = 1'b1;
        last_iss = 0;
        push_frame(0, 511, 0);
        check("bin7_model", exp_pk_mag, 32'h8000_0000);
        first_issue("f1", t0);
        t1 = -1;
        for (int m = 0; m < 20; m++) begin
            @(negedge clk);
            if (mvalid) begin
                t1 = cyc;
                break;
            end
        end
        check("f1_latency", t1 - t0, 5);
        n = 0;
        while (mvalid && n < 600) begin
            n++;
            @(negedge clk);
        end
        check("f1_burst_len", n, 512);
        wait_frame("f1");
        check("f1_exp", mexp, 10);
`ifdef FFT_MAG_PEAK_EN
        check("f1_peak", {pbin, pmag}, {10'd7, 32'h8000_0000});
`else
        check("f1_peak_tied", {pbin, pmag}, 0);
`endif
        fft_done = 1'b0;
        repeat (3) @(posedge clk);
        #1;

        // Frame 2: random bins with ready toggling every 3 cycles
        for (int k = 0; k < 1024; k++) begin
            re_mem[k] = 16'($urandom);
            im_mem[k] = 16'($urandom);
        end
        halt_seen = 0;
        last_iss = 0;
        tog_cnt = 0;
        tog_en = 1;
        fft_done = 1'b1;
        push_frame(0, 511, 0);
        wait_frame("f2");
        tog_en = 0;
        @(posedge clk);
        #2;
        ready = 1'b1;
        check("f2_issue_halted", halt_seen, 1);
        check("f2_credit_bound", longint'(max_out <= 8), 1);
`ifdef FFT_MAG_PEAK_EN
        check("f2_peak", {pbin, pmag}, {exp_pk_bin, exp_pk_mag});
`endif
        fft_done = 1'b0;
        repeat (3) @(posedge clk);
        #1;

        // Frame 3: reset in the cycle bin 200 is issued, then a clean restart
        for (int k = 0; k < 1024; k++) begin
            re_mem[k] = 16'(k);
            im_mem[k] = 16'sd0;
        end
        fft_done = 1'b1;
        last_iss = 0;
        push_frame(0, 511, 0);
        found = 0;
        for (int m = 0; m < 2000; m++) begin
            @(posedge clk);
            #1;
            if (dmaact && dmaa == 10'd200) begin
                found = 1;
                break;
            end
        end
        check("f3_reach_bin200", found, 1);
        reset = 1'b1;
        fft_done = 1'b0;
        fd0 = fd_cnt;
        @(posedge clk);
        #1;
        check_all_zero("midrst");
        sb.delete();
        reset = 1'b0;
        repeat (50) @(posedge clk);
        #1;
        check("midrst_no_done", fd_cnt, fd0);
        check("midrst_idle", {busy, mvalid}, 0);
        last_iss = 0;
        fft_done = 1'b1;
        push_frame(0, 511, 0);
        first_issue("f3r", t0);
        wait_frame("f3r");
        fft_done = 1'b0;
        repeat (3) @(posedge clk);
        #1;

        // Frame 4: equal peaks at bins 40 and 300, negative exponent
        for (int k = 0; k < 1024; k++) begin
            re_mem[k] = 16'(k % 20);
            im_mem[k] = 16'sd0;
        end
        re_mem[40]  = 16'sd30;
        re_mem[300] = 16'sd0;
        im_mem[300] = 16'sd30;
        bfpexp = -8'sd3;
        fft_done = 1'b1;
        push_frame(0, 511, 0);
        wait_frame("f4");
        check("f4_exp", mexp, -6);
`ifdef FFT_MAG_PEAK_EN
        check("f4_peak", {pbin, pmag}, {10'd40, 32'd900});
`else
        check("f4_peak_tied", {pbin, pmag}, 0);
`endif
        fft_done = 1'b0;
        repeat (3) @(posedge clk);
        #1;

        // Windowed instance: bins 100..103, fft_done held high for 2000 cycles
        for (int k = 0; k < 1024; k++) begin
            re_mem[k] = 16'(k);
            im_mem[k] = 16'(k);
        end
        wi0 = w_iss;
        wp0 = w_pop;
        wf0 = w_fd;
        w_fft_done = 1'b1;
        push_frame(100, 103, 1);
        repeat (2000) @(posedge clk);
        #1;
        check("win_words", w_pop - wp0, 4);
        check("win_issues", w_iss - wi0, 4);
        check("win_done_pulses", w_fd - wf0, 1);
        check("win_sb_empty", sbw.size(), 0);
        check("win_exp", w_exp, -6);
        w_fft_done = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        check("win_no_restart", w_iss - wi0, 4);
        w_fft_done = 1'b1;
        push_frame(100, 103, 1);
        repeat (50) @(posedge clk);
        #1;
        check("win_words2", w_pop - wp0, 8);
        check("win_done_pulses2", w_fd - wf0, 2);
        check("win_sb_empty2", sbw.size(), 0);
        w_fft_done = 1'b0;
        repeat (5) @(posedge clk);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/fft_mag_streamer.md
Name: fft_mag_streamer

Overview:
Reads completed FFT bins over the FFT core's DMA read port and computes exact squared magnitude re²+im² per bin. Results stream out on a valid/ready interface at up to one bin per clock. This replaces the earlier one-bin-per-several-cycles, index-driven magnitude path. Sits between the R2FFT core and the spectrogram/peak-hashing logic; supports a configurable bin window, backpressure and an optional per-frame peak tracker.

Parameters:
FFT_N, 10, log2 of FFT length; DMA address width.
DW, 16, signed width of each real/imag bin component.
BIN_LO, 0, first bin read per frame (0 <= BIN_LO <= BIN_HI).
BIN_HI, 511, last bin read per frame (BIN_HI < 2^FFT_N).
RD_LAT, 2, cycles from dmaact_o to valid dmadr_*_i (fixed, >= 1).
FIFO_DEPTH, 8, output FIFO entries; power of 2, >= RD_LAT+3 for full throughput.

Ports:
clk  in  1  clock
reset  in  1  reset
fft_done_i  in  1  level; FFT results valid in core RAM
bfpexp_i  in  8  signed block-floating-point exponent from the FFT core
dmaact_o  out  1  DMA read strobe
dmaa_o  out  FFT_N  DMA read address
dmadr_real_i  in  DW  signed real part, valid RD_LAT cycles after the strobe
dmadr_imag_i  in  DW  signed imag part
mag_valid_o  out  1  output word valid
mag_ready_i  in  1  downstream accepts
mag_data_o  out  2*DW  unsigned re²+im²
mag_bin_o  out  FFT_N  bin index of mag_data_o
mag_last_o  out  1  high with bin BIN_HI
mag_exp_o  out  9  signed 2*bfpexp latched at frame start
busy_o  out  1  frame in progress
frame_done_o  out  1  one-cycle pulse at frame completion
peak_bin_o  out  FFT_N  bin with the largest magnitude in the last frame (feature)
peak_mag_o  out  2*DW  that bin's magnitude (feature)

Behaviour:
- reset is synchronous and active-high. On reset, all outputs are 0, the FIFO is flushed, outstanding reads are discarded and the FSM enters IDLE. Reset mid-frame aborts the frame, and no frame_done_o pulse is issued.
- FSM states: IDLE, ISSUE, DRAIN, DONE, REARM.
- IDLE:
  - When fft_done_i=1, latch mag_exp_o <= 2*bfpexp_i, set addr=BIN_LO, clear the peak, set busy_o=1 and go to ISSUE.
- ISSUE:
  - Assert dmaact_o with dmaa_o=addr in a cycle only when fifo_count + inflight < FIFO_DEPTH. This credit check counts pending reads, so the FIFO can never overflow.
  - Increment addr after each issue.
  - After issuing BIN_HI, go to DRAIN.
- DRAIN:
  - Go to DONE when inflight=0 and the FIFO is empty, i.e. the last word has been accepted.
- DONE:
  - One cycle: frame_done_o=1, busy_o=0, update peak_*_o. Then go to REARM.
- REARM:
  - Wait for fft_done_i=0, then go to IDLE. A level-held fft_done_i never restarts a frame.
- Datapath pipeline:
  - Squares registered at cycle t+RD_LAT+1.
  - Sum registered and pushed at t+RD_LAT+2.
  - Visible on the output at t+RD_LAT+3.
- Arithmetic:
  - Full-precision signed DW×DW squares; unsigned 2*DW-bit sum.
  - Maximum value (-2^(DW-1))²·2 = 2^(2DW-1) fits in 2*DW bits, so no saturation is needed.
- Output is FIFO-backed:
  - mag_valid_o = FIFO not empty.
  - A word is popped when mag_valid_o && mag_ready_i.
  - mag_data_o, mag_bin_o and mag_last_o hold stable while valid is high and ready is low.
  - Simultaneous push and pop in one cycle leaves the count unchanged.
- Throughput: one bin per clock when mag_ready_i is held high and FIFO_DEPTH >= RD_LAT+3.
- fft_done_i dropping mid-frame is ignored; the frame completes.

Optional Feature:
FFT_MAG_PEAK_EN
- Defined:
  - Tracks the maximum magnitude per frame on each FIFO push; updates only on strictly greater values, so the lowest bin wins ties.
  - peak_bin_o and peak_mag_o are updated in DONE and held until the next DONE or reset.
- Undefined: peak_bin_o and peak_mag_o are tied to 0 and no tracker logic is built.

Test Plan:
- Defaults, mag_ready_i=1, fft_done_i rises, bin k holds re=k, im=0 -> first dmaact_o with dmaa_o=0; first mag_valid_o 5 cycles later. 512 consecutive words with mag_data_o=k², mag_bin_o=k. mag_last_o only at bin 511; frame_done_o pulses once.
- re=im=-32768 at bin 7 -> mag_data_o=32'h8000_0000 exactly.
- mag_ready_i toggling 1/0 every 3 cycles, random bins -> no word lost or duplicated, bin order 0..511, data stable while stalled, dmaact_o halts when credits are exhausted.
- BIN_LO=100, BIN_HI=103, fft_done_i held high for 2000 cycles -> exactly 4 words (bins 100..103), one frame_done_o, no restart until fft_done_i falls and rises again.
- Reset asserted mid-frame at bin 200 -> next cycle all outputs 0 and FIFO empty; a fresh fft_done_i rise restarts from BIN_LO.
- FFT_MAG_PEAK_EN defined, bins 40 and 300 both have magnitude 900, all others smaller, bfpexp_i=-3 -> peak_bin_o=40, peak_mag_o=900, mag_exp_o=-6.
